// File: rtl/my_seg7_scan.sv
// Multiplexed N-digit common-cathode 7-segment scanner with blanking gap, dwell, PWM and tear-free updates.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
module my_seg7_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned TW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   num,
    input  logic                  upd,
    input  logic [TW-1:0]         dwell,
    input  logic [TW-1:0]         blank,
    input  logic [3:0]            bright,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     seg_gnd,
    output logic                  frame_done,
    output logic                  upd_pending
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       len_q, len_d;
    logic [3:0]          sub_q, sub_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic                pflag_q, pflag_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   gnd_q, gnd_d;
    logic                fd_q, fd_d;

    logic [TW-1:0]       on_len;
    logic                phase_last;
    logic                frame_end;
    logic [3:0]          nib;
    logic                hidden;
`ifdef SEG7_SCAN_LZB_EN
    logic [IW-1:0]       top;
`endif

    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign on_len     = (dwell == '0) ? TW'(1) : dwell;
    assign phase_last = (cnt_q == len_q - TW'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sub_d     = sub_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        pflag_d   = pflag_q;
        fd_d      = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    idx_d = '0;
                    cnt_d = '0;
                    sub_d = '0;
                    if (blank != '0) begin
                        state_d = S_BLANK;
                        len_d   = blank;
                    end else begin
                        state_d = S_ON;
                        len_d   = on_len;
                    end
                end
            end
            S_BLANK: begin
                if (phase_last) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    sub_d   = '0;
                    len_d   = on_len;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_ON: begin
                sub_d = (sub_q == 4'd14) ? 4'd0 : sub_q + 4'd1;
                if (phase_last) begin
                    cnt_d = '0;
                    sub_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                    if (blank != '0) begin
                        state_d = S_BLANK;
                        len_d   = blank;
                    end else begin
                        state_d = S_ON;
                        len_d   = on_len;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable overrides everything, including a frame boundary on this edge.
        if (!en) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            sub_d     = '0;
            frame_end = 1'b0;
        end

        if (frame_end) begin
            fd_d = 1'b1;
            if (upd) begin
                shadow_d = num;
                pend_d   = num;
                pflag_d  = 1'b0;
            end else if (pflag_q) begin
                shadow_d = pend_q;
                pflag_d  = 1'b0;
            end
        end else if (upd) begin
            pend_d  = num;
            pflag_d = 1'b1;
        end

        nib = 4'h0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) nib = shadow_d[4*i +: 4];
        end

`ifdef SEG7_SCAN_LZB_EN
        top = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (shadow_d[4*i +: 4] != 4'h0) top = IW'(i);
        end
        hidden = (idx_d > top);
`else
        hidden = 1'b0;
`endif

        // Outputs are derived from next-state values so they register on the same edge.
        seg_d = '0;
        gnd_d = '1;
        if (state_d == S_ON && !hidden) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (idx_d == IW'(i)) gnd_d[i] = 1'b0;
            end
            if (sub_d < bright) seg_d = decode(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            sub_q    <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            seg_q    <= '0;
            gnd_q    <= '1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sub_q    <= sub_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            seg_q    <= seg_d;
            gnd_q    <= gnd_d;
            fd_q     <= fd_d;
        end
    end

    assign seg         = seg_q;
    assign seg_gnd     = gnd_q;
    assign frame_done  = fd_q;
    assign upd_pending = pflag_q;

endmodule

// File: tb/tb_my_seg7_scan.sv
// Self-checking bench for my_seg7_scan: per-cycle scoreboard of expected display frames.
module tb_my_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n, en, upd;
    logic [15:0] num, dwell, blank;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic [3:0]  seg_gnd;
    logic        frame_done, upd_pending;

    my_seg7_scan #(.DIGITS(4), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .num(num), .upd(upd),
        .dwell(dwell), .blank(blank), .bright(bright),
        .seg(seg), .seg_gnd(seg_gnd), .frame_done(frame_done), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic       fd;
        logic       pend;
        logic [3:0] gnd;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0] num;
        int          dw;
        int          bl;
        int          br;
        int          exp_len;
        logic [6:0]  exp_d0;
    } vec_t;

    typedef struct {
        int          k;
        logic        en;
        logic        upd;
        logic [15:0] num;
    } act_t;

    exp_t        sb[$];
    act_t        acts[$];
    int          checks = 0;
    int          passed = 0;
    logic [15:0] model_shadow = 16'h0000;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic push_idle(input logic pend);
        exp_t e;
        e = '{fd: 1'b0, pend: pend, gnd: 4'hF, seg: 7'h00};
        sb.push_back(e);
    endtask

    task automatic gen_frame(input logic [15:0] val, input int dw, input int bl, input int br,
                             input logic fd_first, input logic pend);
        int   dwe;
        int   top;
        bit   first;
        exp_t e;
        logic [3:0] nib;
        dwe   = (dw == 0) ? 1 : dw;
        top   = 0;
        first = 1'b1;
`ifdef SEG7_SCAN_LZB_EN
        for (int d = 1; d < 4; d++) if (val[4*d +: 4] != 4'h0) top = d;
`else
        top = 3;
`endif
        for (int d = 0; d < 4; d++) begin
            nib = val[4*d +: 4];
            for (int c = 0; c < bl; c++) begin
                e = '{fd: first ? fd_first : 1'b0, pend: pend, gnd: 4'hF, seg: 7'h00};
                first = 1'b0;
                sb.push_back(e);
            end
            for (int c = 0; c < dwe; c++) begin
                e.fd   = first ? fd_first : 1'b0;
                e.pend = pend;
                e.gnd  = 4'hF & ~(4'b0001 << d);
                e.seg  = ((c % 15) < br) ? DEC[nib] : 7'h00;
                if (d > top) begin
                    e.gnd = 4'hF;
                    e.seg = 7'h00;
                end
                first = 1'b0;
                sb.push_back(e);
            end
        end
    endtask

    // Drains the scoreboard one cycle at a time, applying scheduled input actions after each sample.
    task automatic run_q(input int probe_k, output int fd_k, output logic [6:0] probe_seg);
        int   k;
        exp_t e;
        exp_t a;
        act_t x;
        k         = 0;
        fd_k      = -1;
        probe_seg = 7'h00;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            a = {frame_done, upd_pending, seg_gnd, seg};
            checks++;
            if (a === e) passed++;
            else $display("FAIL scan[%0d]: got fd=%b pend=%b gnd=%b seg=%b, want fd=%b pend=%b gnd=%b seg=%b",
                          k, a.fd, a.pend, a.gnd, a.seg, e.fd, e.pend, e.gnd, e.seg);
            if (frame_done === 1'b1 && fd_k < 0) fd_k = k;
            if (k == probe_k) probe_seg = seg;
            upd = 1'b0;
            while (acts.size() > 0 && acts[0].k == k) begin
                x   = acts.pop_front();
                en  = x.en;
                upd = x.upd;
                if (x.upd) num = x.num;
            end
            k++;
        end
        acts.delete();
    endtask

    task automatic scenario(input vec_t v, input int idx);
        int         fdk;
        logic [6:0] ps;
        act_t       x;
        num    = v.num;
        dwell  = 16'(v.dw);
        blank  = 16'(v.bl);
        bright = 4'(v.br);
        en     = 1'b1;
        upd    = 1'b1;
        gen_frame(model_shadow, v.dw, v.bl, v.br, 1'b0, 1'b1);
        gen_frame(v.num, v.dw, v.bl, v.br, 1'b1, 1'b0);
        push_idle(1'b0);
        x = '{k: sb.size() - 2, en: 1'b0, upd: 1'b0, num: 16'h0};
        acts.push_back(x);
        run_q(v.exp_len + v.bl, fdk, ps);
        model_shadow = v.num;
        check_int($sformatf("frame_len[%0d]", idx), fdk, v.exp_len);
        check_int($sformatf("digit0_seg[%0d]", idx), int'(ps), int'(v.exp_d0));
    endtask

    vec_t vecs[5];

    initial begin : main
        int         fdk;
        logic [6:0] ps;
        exp_t       e;
        act_t       x;
        exp_t       a;

        vecs[0] = '{num: 16'h12AF, dw: 4,  bl: 2, br: 15, exp_len: 24,  exp_d0: 7'b1000111};
        vecs[1] = '{num: 16'h3C5E, dw: 30, bl: 0, br: 5,  exp_len: 120, exp_d0: 7'b1001111};
        vecs[2] = '{num: 16'h7B90, dw: 3,  bl: 0, br: 0,  exp_len: 12,  exp_d0: 7'b0000000};
        vecs[3] = '{num: 16'h8642, dw: 0,  bl: 1, br: 15, exp_len: 8,   exp_d0: 7'b1101101};
        vecs[4] = '{num: 16'hDEAD, dw: 2,  bl: 3, br: 9,  exp_len: 20,  exp_d0: 7'b0111101};

        rst_n  = 1'b0;
        en     = 1'b1;
        upd    = 1'b0;
        num    = 16'h0;
        dwell  = 16'd4;
        blank  = 16'd2;
        bright = 4'd15;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = {frame_done, upd_pending, seg_gnd, seg};
            checks++;
            if (a === 13'b0_0_1111_0000000) passed++;
            else $display("FAIL reset[%0d]: got %b, want %b", i, a, 13'b0_0_1111_0000000);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) scenario(vecs[i], i);

        // Mid-frame updates (last one wins), then an update on the frame boundary edge.
        dwell  = 16'd2;
        blank  = 16'd1;
        bright = 4'd15;
        en     = 1'b1;
        upd    = 1'b0;
        gen_frame(model_shadow, 2, 1, 15, 1'b0, 1'b0);
        for (int i = 6; i < 12; i++) begin
            e      = sb[i];
            e.pend = 1'b1;
            sb[i]  = e;
        end
        gen_frame(16'h3333, 2, 1, 15, 1'b1, 1'b0);
        gen_frame(16'h2222, 2, 1, 15, 1'b1, 1'b0);
        push_idle(1'b0);
        x = '{k: 5,  en: 1'b1, upd: 1'b1, num: 16'h1111}; acts.push_back(x);
        x = '{k: 7,  en: 1'b1, upd: 1'b1, num: 16'h3333}; acts.push_back(x);
        x = '{k: 23, en: 1'b1, upd: 1'b1, num: 16'h2222}; acts.push_back(x);
        x = '{k: 35, en: 1'b0, upd: 1'b0, num: 16'h0};    acts.push_back(x);
        run_q(13, fdk, ps);
        model_shadow = 16'h2222;
        check_int("tearfree_fd_k", fdk, 12);
        check_int("tearfree_digit0", int'(ps), int'(DEC[3]));

        // Disable during digit 2 ON, then re-enable: restart at digit 0 with no frame_done.
        en  = 1'b1;
        upd = 1'b0;
        gen_frame(model_shadow, 2, 1, 15, 1'b0, 1'b0);
        while (sb.size() > 8) void'(sb.pop_back());
        push_idle(1'b0);
        gen_frame(model_shadow, 2, 1, 15, 1'b0, 1'b0);
        push_idle(1'b0);
        x = '{k: 7,  en: 1'b0, upd: 1'b0, num: 16'h0}; acts.push_back(x);
        x = '{k: 8,  en: 1'b1, upd: 1'b0, num: 16'h0}; acts.push_back(x);
        x = '{k: 20, en: 1'b0, upd: 1'b0, num: 16'h0}; acts.push_back(x);
        run_q(7, fdk, ps);
        check_int("disable_no_fd", fdk, -1);
        check_int("disable_digit2", int'(ps), int'(DEC[2]));

`ifdef SEG7_SCAN_LZB_EN
        begin
            vec_t lz;
            lz = '{num: 16'h0050, dw: 2, bl: 1, br: 15, exp_len: 12, exp_d0: 7'b1111110};
            scenario(lz, 5);
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
